rom_sequencer: RTL and testbench

Parametrised on-chip ROM playback engine: steps a synchronous ROM's address through a programmable range at a programmable rate and presents each word with a valid strobe to the display path (e.g. the BCD/595 driver).
Replaces the fixed cascaded-divider, free-running 3-bit address counter with a single-clock-domain block.
Adds a rate divider, range limits, loop/one-shot/ping-pong modes, start/stop/pause control and a done indication.
Sits between the ROM IP (clocked by the same clk) and the display driver.

---
 rtl/rom_seq_pkg.sv | 33 +++
 rtl/rom_sequencer_if.sv | 30 +++
 rtl/rate_tick.sv | 41 ++++
 rtl/rom_sequencer.sv | 149 ++++++++++++++
 tb/tb_rom_sequencer.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/rom_seq_pkg.sv
// Shared encodings for the ROM playback sequencer: playback modes, FSM states
// and ping-pong direction, plus the rule that resolves the effective mode at start.
package rom_seq_pkg;

   typedef enum logic [1:0] {
      MODE_LOOP     = 2'd0,
      MODE_ONESHOT  = 2'd1,
      MODE_PINGPONG = 2'd2,
      MODE_LOOP_ALT = 2'd3
   } mode_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_e;

   // Ping-pong needs a non-empty ascending range; otherwise it degenerates to loop.
   function automatic mode_e eff_mode(input logic [1:0] mode, input logic range_asc);
      mode_e m;
      case (mode)
         2'd1:    m = MODE_ONESHOT;
         2'd2:    m = range_asc ? MODE_PINGPONG : MODE_LOOP;
         default: m = MODE_LOOP;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/rom_sequencer_if.sv
// Control, ROM-side and display-side signals of the ROM playback sequencer.
interface rom_sequencer_if #(
   parameter int unsigned ADDR_W = 3,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DIV_W  = 24
);
   logic              en;
   logic              start;
   logic              stop;
   logic [1:0]        mode;
   logic [DIV_W-1:0]  div;
   logic [ADDR_W-1:0] first_addr;
   logic [ADDR_W-1:0] last_addr;
   logic [ADDR_W-1:0] rom_addr;
   logic [DATA_W-1:0] rom_q;
   logic [DATA_W-1:0] data;
   logic              data_valid;
   logic              busy;
   logic              done;

   modport master (
      input  en, start, stop, mode, div, first_addr, last_addr, rom_q,
      output rom_addr, data, data_valid, busy, done
   );

   modport slave (
      output en, start, stop, mode, div, first_addr, last_addr, rom_q,
      input  rom_addr, data, data_valid, busy, done
   );
endinterface

// File: rtl/rate_tick.sv
// Loadable step-period down-counter: emits tick_c on the last cycle of each
// period while running and enabled, then reloads the latched period.
module rate_tick #(
   parameter int unsigned DIV_W = 24
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [DIV_W-1:0] load_period,
   input  logic             run,
   input  logic             en,
   output logic             tick_c
);

   logic [DIV_W-1:0] period_q, period_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;

   assign tick_c = run && en && (cnt_q <= DIV_W'(1));

   always_comb begin
      period_d = period_q;
      cnt_d    = cnt_q;
      if (load) begin
         period_d = load_period;
         cnt_d    = load_period;
      end else if (run && en) begin
         cnt_d = (cnt_q <= DIV_W'(1)) ? period_q : cnt_q - DIV_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         period_q <= DIV_W'(1);
         cnt_q    <= DIV_W'(1);
      end else begin
         period_q <= period_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/rom_sequencer.sv
// ROM playback engine: walks the ROM address over a latched range at a
// programmable rate and presents each fetched word with a one-cycle valid strobe.
module rom_sequencer
   import rom_seq_pkg::*;
#(
   parameter int unsigned ADDR_W = 3,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DIV_W  = 24
) (
   input logic               clk,
   input logic               rst,
   rom_sequencer_if.master   bus
);

   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

   state_e            state_q, state_d;
   mode_e             mode_q, mode_d;
   dir_e              dir_q, dir_d;
   logic [ADDR_W-1:0] first_q, first_d;
   logic [ADDR_W-1:0] last_q, last_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [1:0]        vld_q, vld_d;
   logic              data_valid_q, data_valid_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic              load_c;
   logic              issue_c;
   logic              run_c;
   logic              tick_c;
   logic [DIV_W-1:0]  period_c;

   assign period_c = (bus.div == '0) ? DIV_W'(1) : bus.div;
   assign run_c    = (state_q == ST_RUN);

   rate_tick #(.DIV_W(DIV_W)) u_rate_tick (
      .clk         (clk),
      .rst_n       (rst),
      .load        (load_c),
      .load_period (period_c),
      .run         (run_c),
      .en          (bus.en),
      .tick_c      (tick_c)
   );

   // Next-state, address stepping and fetch-pipeline control.
   always_comb begin
      state_d      = state_q;
      mode_d       = mode_q;
      dir_d        = dir_q;
      first_d      = first_q;
      last_d       = last_q;
      addr_d       = addr_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      load_c       = 1'b0;
      issue_c      = 1'b0;
      data_d       = vld_q[1] ? bus.rom_q : data_q;
      data_valid_d = vld_q[1];

      if (bus.stop) begin
         state_d      = ST_IDLE;
         busy_d       = 1'b0;
         data_d       = data_q;
         data_valid_d = 1'b0;
      end else if (bus.start) begin
         state_d = ST_RUN;
         mode_d  = eff_mode(bus.mode, bus.first_addr < bus.last_addr);
         first_d = bus.first_addr;
         last_d  = bus.last_addr;
         addr_d  = bus.first_addr;
         dir_d   = DIR_UP;
         busy_d  = 1'b1;
         load_c  = 1'b1;
         issue_c = 1'b1;
      end else if (run_c && tick_c) begin
         issue_c = 1'b1;
         case (mode_q)
            MODE_ONESHOT: begin
               if (addr_q == last_q) begin
                  issue_c = 1'b0;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = ST_IDLE;
               end else begin
                  addr_d = addr_q + ADDR_ONE;
               end
            end
            MODE_PINGPONG: begin
               if (dir_q == DIR_UP) begin
                  if (addr_q == last_q) begin
                     dir_d  = DIR_DOWN;
                     addr_d = addr_q - ADDR_ONE;
                  end else begin
                     addr_d = addr_q + ADDR_ONE;
                  end
               end else begin
                  if (addr_q == first_q) begin
                     dir_d  = DIR_UP;
                     addr_d = addr_q + ADDR_ONE;
                  end else begin
                     addr_d = addr_q - ADDR_ONE;
                  end
               end
            end
            default: addr_d = (addr_q == last_q) ? first_q : addr_q + ADDR_ONE;
         endcase
      end

      vld_d = bus.stop ? 2'b00 : {vld_q[0], issue_c};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         mode_q       <= MODE_LOOP;
         dir_q        <= DIR_UP;
         first_q      <= '0;
         last_q       <= '0;
         addr_q       <= '0;
         data_q       <= '0;
         vld_q        <= '0;
         data_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         mode_q       <= mode_d;
         dir_q        <= dir_d;
         first_q      <= first_d;
         last_q       <= last_d;
         addr_q       <= addr_d;
         data_q       <= data_d;
         vld_q        <= vld_d;
         data_valid_q <= data_valid_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign bus.rom_addr   = addr_q;
   assign bus.data       = data_q;
   assign bus.data_valid = data_valid_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;

endmodule

// File: tb/tb_rom_sequencer.sv
// Directed self-checking bench for rom_sequencer with a synchronous ROM model.
module tb_rom_sequencer;

   localparam int unsigned ADDR_W = 3;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned DIV_W  = 24;

   logic clk = 1'b0;
   logic rst_n;
   int   n_assert = 0;
   int   n_fail   = 0;

   int loop_seq [6] = '{2, 3, 4, 5, 2, 3};
   int os_addr  [7] = '{0, 1, 2, 2, 2, 2, 2};
   int os_busy  [7] = '{1, 1, 1, 0, 0, 0, 0};
   int os_done  [7] = '{0, 0, 0, 1, 0, 0, 0};
   int os_dv    [7] = '{0, 0, 1, 1, 1, 0, 0};
   int pp_seq   [7] = '{1, 2, 3, 2, 1, 2, 3};
   int wr_seq   [5] = '{6, 7, 0, 1, 6};

   rom_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DIV_W(DIV_W)) bus ();

   rom_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DIV_W(DIV_W)) dut (
      .clk (clk),
      .rst (rst_n),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rw(input logic [2:0] a);
      return 32'hA5A5_0000 + {29'd0, a} * 32'h0000_1111;
   endfunction

   always @(posedge clk) bus.rom_q <= rw(bus.rom_addr);

   function automatic int pause_addr(input int e);
      if (e < 3)  return 0;
      if (e < 6)  return 1;
      if (e < 14) return 2;
      if (e < 17) return 3;
      if (e < 20) return 4;
      return 5;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
      n_assert++;
      assert (obs === want) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic start_run(input logic [1:0] m, input int f, input int l, input int d);
      bus.mode       = m;
      bus.first_addr = 3'(f);
      bus.last_addr  = 3'(l);
      bus.div        = 24'(d);
      bus.start      = 1'b1;
      cyc();
      bus.start      = 1'b0;
   endtask

   task automatic stop_run();
      bus.stop = 1'b1;
      cyc();
      bus.stop = 1'b0;
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_addr"}, 64'(bus.rom_addr), 64'd0);
      chk({tag, "_data"}, 64'(bus.data), 64'd0);
      chk({tag, "_dv"},   64'(bus.data_valid), 64'd0);
      chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
      chk({tag, "_done"}, 64'(bus.done), 64'd0);
   endtask

   initial begin
      bus.en         = 1'b1;
      bus.start      = 1'b0;
      bus.stop       = 1'b0;
      bus.mode       = 2'd0;
      bus.div        = 24'd1;
      bus.first_addr = 3'd0;
      bus.last_addr  = 3'd0;
      rst_n          = 1'b0;
      #2;
      chk_idle_outputs("reset");
      #10;
      rst_n = 1'b1;
      cyc();

      // Loop over 2..5, four cycles per step
      start_run(2'd0, 2, 5, 4);
      for (int e = 0; e < 22; e++) begin
         if (e > 0) cyc();
         chk("loop_addr", 64'(bus.rom_addr), 64'(loop_seq[e / 4]));
         chk("loop_dv", 64'(bus.data_valid), 64'(e % 4 == 2));
         chk("loop_done", 64'(bus.done), 64'd0);
         if (e % 4 == 2) chk("loop_data", 64'(bus.data), 64'(rw(3'(loop_seq[(e - 2) / 4]))));
      end
      stop_run();
      chk("stop_busy", 64'(bus.busy), 64'd0);
      for (int e = 0; e < 6; e++) begin
         chk("stop_dv", 64'(bus.data_valid), 64'd0);
         chk("stop_done", 64'(bus.done), 64'd0);
         chk("stop_addr", 64'(bus.rom_addr), 64'd3);
         chk("stop_data", 64'(bus.data), 64'(rw(3'd2)));
         cyc();
      end

      // One-shot over 0..2 at full rate
      start_run(2'd1, 0, 2, 1);
      for (int e = 0; e < 7; e++) begin
         if (e > 0) cyc();
         chk("os_addr", 64'(bus.rom_addr), 64'(os_addr[e]));
         chk("os_busy", 64'(bus.busy), 64'(os_busy[e]));
         chk("os_done", 64'(bus.done), 64'(os_done[e]));
         chk("os_dv", 64'(bus.data_valid), 64'(os_dv[e]));
         if (e >= 2 && e <= 4) chk("os_data", 64'(bus.data), 64'(rw(3'(os_addr[e - 2]))));
      end
      chk("os_final_data", 64'(bus.data), 64'(rw(3'd2)));

      // Ping-pong over 1..3, two cycles per step
      start_run(2'd2, 1, 3, 2);
      for (int e = 0; e < 14; e++) begin
         if (e > 0) cyc();
         chk("pp_addr", 64'(bus.rom_addr), 64'(pp_seq[e / 2]));
         chk("pp_dv", 64'(bus.data_valid), 64'(e >= 2 && e % 2 == 0));
         chk("pp_done", 64'(bus.done), 64'd0);
         if (e >= 2 && e % 2 == 0) chk("pp_data", 64'(bus.data), 64'(rw(3'(pp_seq[(e - 2) / 2]))));
      end

      // Restart while running: ping-pong with a wrapped range runs as loop
      start_run(2'd2, 6, 1, 1);
      for (int e = 0; e < 5; e++) begin
         if (e > 0) cyc();
         chk("ppw_addr", 64'(bus.rom_addr), 64'(wr_seq[e]));
         chk("ppw_busy", 64'(bus.busy), 64'd1);
         if (e >= 2) begin
            chk("ppw_dv", 64'(bus.data_valid), 64'd1);
            chk("ppw_data", 64'(bus.data), 64'(rw(3'(wr_seq[e - 2]))));
         end
      end
      stop_run();

      // Pause: en low across edges 8..12 stretches the third step to 8 cycles
      start_run(2'd0, 0, 7, 3);
      for (int e = 0; e < 22; e++) begin
         if (e > 0) cyc();
         chk("pause_addr", 64'(bus.rom_addr), 64'(pause_addr(e)));
         chk("pause_dv", 64'(bus.data_valid),
             64'(e == 2 || e == 5 || e == 8 || e == 16 || e == 19));
         if (e == 2 || e == 5 || e == 8 || e == 16 || e == 19)
            chk("pause_data", 64'(bus.data), 64'(rw(3'(pause_addr(e - 2)))));
         if (e == 7)  bus.en = 1'b0;
         if (e == 12) bus.en = 1'b1;
      end
      stop_run();

      // stop and start together: stop wins
      start_run(2'd0, 0, 3, 2);
      cyc();
      cyc();
      cyc();
      bus.stop  = 1'b1;
      bus.start = 1'b1;
      cyc();
      bus.stop  = 1'b0;
      bus.start = 1'b0;
      for (int e = 0; e < 6; e++) begin
         chk("coll_busy", 64'(bus.busy), 64'd0);
         chk("coll_done", 64'(bus.done), 64'd0);
         chk("coll_dv", 64'(bus.data_valid), 64'd0);
         chk("coll_addr", 64'(bus.rom_addr), 64'd1);
         chk("coll_data", 64'(bus.data), 64'(rw(3'd0)));
         cyc();
      end

      // Asynchronous reset mid-run
      start_run(2'd0, 0, 7, 1);
      cyc();
      cyc();
      cyc();
      chk("prerst_busy", 64'(bus.busy), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_idle_outputs("async_rst");
      cyc();
      rst_n = 1'b1;
      for (int e = 0; e < 4; e++) begin
         cyc();
         chk_idle_outputs("post_rst");
      end

      // div=0 acts as 1; range 7..0 wraps through zero
      start_run(2'd0, 7, 0, 0);
      for (int e = 0; e < 8; e++) begin
         if (e > 0) cyc();
         chk("wrap_addr", 64'(bus.rom_addr), (e % 2 == 0) ? 64'd7 : 64'd0);
         chk("wrap_dv", 64'(bus.data_valid), 64'(e >= 2));
         if (e >= 2) chk("wrap_data", 64'(bus.data), 64'(rw((e % 2 == 0) ? 3'd7 : 3'd0)));
      end
      stop_run();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
